// File: rtl/wave_mixer.sv
// wave_mixer: N-channel sample mixer that sums one channel per clock with per-channel mute/shift.
// Define WAVE_MIXER_SATURATE_EN to clamp the output at full scale; otherwise the sum wraps.
module wave_mixer #(
    parameter int N_CH  = 4,
    parameter int IN_W  = 11,
    parameter int OUT_W = 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ena,
    input  logic                   sample_strobe,
    input  logic [N_CH*IN_W-1:0]   channels,
    input  logic [N_CH-1:0]        mute,
    input  logic [2*N_CH-1:0]      atten,
    output logic [OUT_W-1:0]       out,
    output logic                   out_valid,
    output logic                   busy,
    output logic                   overrun
);
    localparam int ACC_W = IN_W + $clog2(N_CH) + 1;
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [N_CH*IN_W-1:0]   ch_p0;
    logic [N_CH-1:0]        mute_p0;
    logic [2*N_CH-1:0]      atten_p0;
    logic [ACC_W-1:0]       acc_p1;
    logic [ACC_W-1:0]       term;

    function automatic logic [OUT_W-1:0] fit_out(input logic [ACC_W-1:0] sum);
`ifdef WAVE_MIXER_SATURATE_EN
        if ((ACC_W+OUT_W)'(sum) > (ACC_W+OUT_W)'({OUT_W{1'b1}}))
            return '1;
`endif
        return OUT_W'(sum);
    endfunction

    // Channel selected by idx, attenuated, or zero when muted.
    always_comb begin
        term = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (idx == IDX_W'(i) && !mute_p0[i])
                term = ACC_W'(ch_p0[i*IN_W +: IN_W] >> atten_p0[2*i +: 2]);
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            acc_p1    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (ena) begin
                // A strobe while busy (including the DONE->IDLE edge) is dropped.
                if (sample_strobe && state != IDLE)
                    overrun <= 1'b1;
                case (state)
                    IDLE: begin
                        if (sample_strobe) begin
                            ch_p0    <= channels;
                            mute_p0  <= mute;
                            atten_p0 <= atten;
                            acc_p1   <= '0;
                            idx      <= '0;
                            state    <= ACCUM;
                        end
                    end
                    ACCUM: begin
                        acc_p1 <= acc_p1 + term;
                        if (idx == LAST_IDX) begin
                            idx   <= '0;
                            state <= DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    DONE: begin
                        out       <= fit_out(acc_p1);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_wave_mixer.sv
// tb_wave_mixer: directed plus randomized checks of wave_mixer against an arithmetic reference model.
module tb_wave_mixer;
    localparam int N_CH    = 4;
    localparam int IN_W    = 11;
    localparam int OUT_W   = 12;
    localparam int OUT_MAX = (1 << OUT_W) - 1;
`ifdef WAVE_MIXER_SATURATE_EN
    localparam int FULL_EXP = 4095;
`else
    localparam int FULL_EXP = 4092;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 ena;
    logic                 sample_strobe;
    logic [N_CH*IN_W-1:0] channels;
    logic [N_CH-1:0]      mute;
    logic [2*N_CH-1:0]    atten;
    logic [OUT_W-1:0]     out;
    logic                 out_valid;
    logic                 busy;
    logic                 overrun;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_ovr = 0;
    int lat;

    always #5 clk = ~clk;

    wave_mixer #(.N_CH(N_CH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .ena(ena), .sample_strobe(sample_strobe),
        .channels(channels), .mute(mute), .atten(atten),
        .out(out), .out_valid(out_valid), .busy(busy), .overrun(overrun)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N_CH*IN_W-1:0] pack4(input int a, input int b, input int c, input int d);
        int v[4];
        logic [N_CH*IN_W-1:0] p;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        p = '0;
        for (int i = 0; i < N_CH; i++) p[i*IN_W +: IN_W] = IN_W'(v[i]);
        return p;
    endfunction

    // Sum of unmuted channels divided by 2^atten, then clamped or wrapped to the output width.
    function automatic int ref_mix(input logic [N_CH*IN_W-1:0] chs, input logic [N_CH-1:0] mu,
                                   input logic [2*N_CH-1:0] at);
        int sum = 0;
        for (int i = 0; i < N_CH; i++)
            if (!mu[i]) sum += int'(chs[i*IN_W +: IN_W]) / (1 << int'(at[2*i +: 2]));
`ifdef WAVE_MIXER_SATURATE_EN
        if (sum > OUT_MAX) sum = OUT_MAX;
        return sum;
`else
        return sum % (OUT_MAX + 1);
`endif
    endfunction

    // stall_mode: 0 ena high, 1 ena low on cycles 2..4, 2 random ena.
    // stray_mode: 0 none, 1 strobe on cycle 1, 2 random strobes.
    task automatic run_mix(input string tag, input logic [N_CH*IN_W-1:0] chs, input logic [N_CH-1:0] mu,
                           input logic [2*N_CH-1:0] at, input int stall_mode, input int stray_mode,
                           output int latency);
        int expv, need, k;
        expv = ref_mix(chs, mu, at);
        channels = chs; mute = mu; atten = at;
        ena = 1'b1; sample_strobe = 1'b1;
        tick;
        chk({tag, "/busy_start"}, int'(busy), 1);
        need = N_CH + 1;
        k = 0;
        while (need > 0 && k < 200) begin
            k++;
            channels = (N_CH*IN_W)'({$urandom, $urandom});
            mute     = N_CH'($urandom);
            atten    = (2*N_CH)'($urandom);
            case (stall_mode)
                1:       ena = !(k >= 2 && k <= 4);
                2:       ena = ($urandom_range(0, 3) != 0);
                default: ena = 1'b1;
            endcase
            case (stray_mode)
                1:       sample_strobe = (k == 1);
                2:       sample_strobe = ($urandom_range(0, 4) == 0);
                default: sample_strobe = 1'b0;
            endcase
            if (ena && sample_strobe) exp_ovr = 1;
            if (ena) need--;
            tick;
            if (need > 0) begin
                chk({tag, "/valid_early"}, int'(out_valid), 0);
                chk({tag, "/busy_mid"}, int'(busy), 1);
            end
        end
        latency = k;
        chk({tag, "/timeout"}, need, 0);
        chk({tag, "/valid"}, int'(out_valid), 1);
        chk({tag, "/out"}, int'(out), expv);
        chk({tag, "/busy_end"}, int'(busy), 0);
        chk({tag, "/overrun"}, int'(overrun), exp_ovr);
        ena = 1'b1; sample_strobe = 1'b0;
        tick;
        chk({tag, "/valid_pulse"}, int'(out_valid), 0);
        chk({tag, "/out_hold"}, int'(out), expv);
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; sample_strobe = 1'b0;
        channels = '0; mute = '0; atten = '0;
        tick; tick;
        chk("rst/out", int'(out), 0);
        chk("rst/valid", int'(out_valid), 0);
        chk("rst/busy", int'(busy), 0);
        chk("rst/overrun", int'(overrun), 0);
        rst = 1'b0;
        tick;

        run_mix("sum", pack4(100, 200, 300, 400), 4'b0000, 8'h00, 0, 0, lat);
        chk("sum/const", int'(out), 1000);
        chk("sum/latency", lat, 5);

        run_mix("full", pack4(2047, 2047, 2047, 2047), 4'b0000, 8'h00, 0, 0, lat);
        chk("full/const", int'(out), FULL_EXP);

        run_mix("atten", pack4(1024, 1024, 2000, 0), 4'b0100, 8'b0000_0111, 0, 0, lat);
        chk("atten/const", int'(out), 640);

        run_mix("iso", pack4(10, 10, 10, 10), 4'b0000, 8'h00, 0, 1, lat);
        chk("iso/const", int'(out), 40);
        chk("iso/overrun_set", int'(overrun), 1);
        repeat (4) begin
            tick;
            chk("iso/no_second_valid", int'(out_valid), 0);
        end

        run_mix("stall", pack4(1, 1, 1, 1), 4'b0000, 8'h00, 1, 0, lat);
        chk("stall/const", int'(out), 4);
        chk("stall/latency", lat, 8);

        channels = pack4(300, 300, 300, 300); mute = '0; atten = '0;
        ena = 1'b1; sample_strobe = 1'b1;
        tick;
        sample_strobe = 1'b0;
        tick; tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        exp_ovr = 0;
        chk("midrst/out", int'(out), 0);
        chk("midrst/valid", int'(out_valid), 0);
        chk("midrst/busy", int'(busy), 0);
        chk("midrst/overrun", int'(overrun), 0);
        repeat (8) begin
            tick;
            chk("midrst/no_valid", int'(out_valid), 0);
            chk("midrst/idle", int'(busy), 0);
        end
        run_mix("after_rst", pack4(5, 6, 7, 8), 4'b0000, 8'h00, 0, 0, lat);
        chk("after_rst/const", int'(out), 26);

        for (int t = 0; t < 40; t++) begin
            run_mix("rand", (N_CH*IN_W)'({$urandom, $urandom}),
                    N_CH'($urandom_range(0, 3) == 0 ? $urandom : 0),
                    (2*N_CH)'($urandom), 2, 2, lat);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
